uart_rx_port: RTL and testbench
===============================

// Module: uart_rx_port
// PURPOSE
//  Hardware UART receiver for the icestick SoC. Takes the raw RX pin and
//  delivers framed 8N1 bytes through a one-byte holding register that the
//  core reads as an input port, replacing the bit-banged RX sampling in
//  firmware. Runs in the clk_core domain (39.75 MHz PLL output).
//  Reports framing errors and overruns as sticky status flags.
// PARAMETERS
//  CLKS_PER_BIT  345  clk_core cycles per bit (115200 baud at 39.75 MHz); legal range 4..65535
//  CNT_W         16   width of the bit-timing counter; must hold CLKS_PER_BIT-1
// PORTS
//  clk_core   in   1  core clock; all logic on its rising edge
//  reset      in   1  synchronous, active-high; clears all state
//  rx         in   1  asynchronous serial input, idle high
//  rx_read    in   1  consumer pop strobe; honoured only while rx_valid=1
//  err_clr    in   1  clears frame_err and overrun (1-cycle pulse)
//  rx_data    out  8  holding register, valid while rx_valid=1
//  rx_valid   out  1  holding register contains an unread byte
//  frame_err  out  1  sticky: stop bit sampled low
//  overrun    out  1  sticky: byte completed while holding register was full
//  busy       out  1  FSM not in IDLE
// BEHAVIOUR
//  Reset: rx_data=0, rx_valid=0, frame_err=0, overrun=0, busy=0.
//   Synchroniser flops are preset to 1; FSM=IDLE; counter=0; bit index=0.
//  Sync: rx passes through 2 flops (rx_s). All decisions use rx_s only.
//  FSM states:
//   IDLE:  rx_s=0 -> START; counter loaded with CLKS_PER_BIT/2 - 1.
//   START: counter counts down to 0 (mid start bit). At 0:
//          - rx_s=1 -> IDLE (glitch rejected, no flags change).
//          - rx_s=0 -> DATA; counter=CLKS_PER_BIT-1; index=0.
//   DATA:  at counter 0: shift rx_s into the shift register LSB-first;
//          after index 7 -> STOP; counter reloads to CLKS_PER_BIT-1.
//   STOP:  at counter 0 (mid stop bit):
//          - rx_s=1 -> commit the byte -> IDLE.
//          - rx_s=0 -> set frame_err, discard the byte -> BREAK.
//   BREAK: wait for rx_s=1 -> IDLE. Holds through arbitrarily long breaks.
//  busy=1 in every state except IDLE.
//  Commit rules (cycle of the stop sample, registered next edge):
//   - rx_valid=0: rx_data<=byte; rx_valid<=1.
//   - rx_valid=1 and rx_read=1 same cycle: rx_data<=new byte; rx_valid stays 1;
//     no overrun.
//   - rx_valid=1 and rx_read=0: old byte kept; overrun<=1.
//  rx_read with rx_valid=1 and no commit: rx_valid<=0 next edge; rx_data held.
//   rx_read with rx_valid=0 is ignored.
//  Latency: rx_valid rises 1 cycle after the stop-sample cycle, which is
//   about 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles after the rx falling edge.
//  Flags: frame_err and overrun are sticky until err_clr. If a set event and
//   err_clr occur in the same cycle, the set wins.
//  Reset mid-frame: abandon the frame. No byte and no flags result. After
//   reset is released, receive resumes at the next falling edge of rx_s.
//  The counter never wraps; it is always reloaded before underflow.
// TESTING (sim with CLKS_PER_BIT=8)
//  1. Send 0xA5 8N1 -> rx_valid=1, rx_data=0xA5, frame_err=0, overrun=0;
//     pulse rx_read -> rx_valid=0 on the next cycle.
//  2. rx low for 3 cycles, then high (glitch) -> FSM returns to IDLE,
//     rx_valid=0, no flags set.
//  3. Send 0x3C with the stop bit held low for 20 bit times -> frame_err=1,
//     rx_valid=0; no new frame accepted until rx high; then send 0x11 ->
//     rx_data=0x11.
//  4. Send 0x01, then 0x02 with no read -> rx_data=0x01, overrun=1;
//     err_clr -> overrun=0.
//  5. Send 0x55, then 0x66, with rx_read asserted in the 0x66 stop-sample
//     cycle -> rx_data=0x66, rx_valid=1, overrun=0.
//  6. Assert reset during DATA of 0x7E -> rx_valid=0 and busy=0 after reset;
//     send 0x7E -> received correctly.

Source files
------------

// File: rtl/uart_rx_port_if.sv
// Consumer-side port bundle of the UART receiver: holding register, pop strobe and status.
// The receiver is the master; the core-side reader is the slave.
interface uart_rx_port_if;
    logic       rx_read;
    logic       err_clr;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    modport master (
        input  rx_read,
        input  err_clr,
        output rx_data,
        output rx_valid,
        output frame_err,
        output overrun,
        output busy
    );

    modport slave (
        output rx_read,
        output err_clr,
        input  rx_data,
        input  rx_valid,
        input  frame_err,
        input  overrun,
        input  busy
    );
endinterface

// File: rtl/uart_rx_port.sv
// 8N1 UART receiver with a one-byte holding register and sticky framing/overrun flags.
// Runs entirely in the clk_core domain; the rx pin is double-synchronised before use.
module uart_rx_port #(
    parameter int unsigned CLKS_PER_BIT = 345,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                  clk_core,
    input  logic                  reset,
    input  logic                  rx,
    uart_rx_port_if.master        bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             sync1_q, rx_s_q;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic             frame_err_q, frame_err_d;
    logic             overrun_q, overrun_d;
    logic             busy_q, busy_d;
    logic             commit_s;
    logic             ferr_set_s;
    logic             ovr_set_s;

    // Frame sequencing: every decision is taken when the bit counter reaches zero (mid-bit).
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        shift_d    = shift_q;
        commit_s   = 1'b0;
        ferr_set_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rx_s_q) begin
                    state_d = START;
                    cnt_d   = HALF_M1;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                if (cnt_q != CNT_ZERO) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else if (rx_s_q) begin
                    state_d = IDLE;
                end else begin
                    state_d = DATA;
                    cnt_d   = FULL_M1;
                    idx_d   = 3'd0;
                end
            end
            DATA: begin
                if (cnt_q != CNT_ZERO) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else begin
                    shift_d = {rx_s_q, shift_q[7:1]};
                    cnt_d   = FULL_M1;
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            STOP: begin
                if (cnt_q != CNT_ZERO) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else if (rx_s_q) begin
                    commit_s = 1'b1;
                    state_d  = IDLE;
                end else begin
                    ferr_set_s = 1'b1;
                    state_d    = BREAK;
                end
            end
            BREAK: begin
                if (rx_s_q) begin
                    state_d = IDLE;
                end else begin
                    state_d = BREAK;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Holding register and sticky flags; a read coinciding with a commit swaps in the new byte.
    always_comb begin
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        ovr_set_s  = 1'b0;
        if (commit_s) begin
            if (!rx_valid_q) begin
                rx_data_d  = shift_q;
                rx_valid_d = 1'b1;
            end else if (bus.rx_read) begin
                rx_data_d  = shift_q;
            end else begin
                ovr_set_s  = 1'b1;
            end
        end else if (bus.rx_read && rx_valid_q) begin
            rx_valid_d = 1'b0;
        end else begin
            rx_valid_d = rx_valid_q;
        end

        if (ferr_set_s) begin
            frame_err_d = 1'b1;
        end else if (bus.err_clr) begin
            frame_err_d = 1'b0;
        end else begin
            frame_err_d = frame_err_q;
        end

        if (ovr_set_s) begin
            overrun_d = 1'b1;
        end else if (bus.err_clr) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end

        busy_d = (state_d != IDLE);
    end

    // State register; the synchroniser presets to idle-high so reset never looks like a start bit.
    always_ff @(posedge clk_core) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= CNT_ZERO;
            idx_q       <= 3'd0;
            shift_q     <= 8'd0;
            sync1_q     <= 1'b1;
            rx_s_q      <= 1'b1;
            rx_data_q   <= 8'd0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            sync1_q     <= rx;
            rx_s_q      <= sync1_q;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.rx_data   = rx_data_q;
    assign bus.rx_valid  = rx_valid_q;
    assign bus.frame_err = frame_err_q;
    assign bus.overrun   = overrun_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_uart_rx_port.sv
// Directed bench for uart_rx_port at 8 clocks per bit; frames are driven cycle by cycle
// on the falling clock edge and outputs are sampled on the falling edge too.
module tb_uart_rx_port;

    localparam int CPB = 8;

    logic clk_core = 1'b0;
    logic reset    = 1'b1;
    logic rx       = 1'b1;

    int n_tests = 0;
    int n_fail  = 0;

    uart_rx_port_if bus ();

    uart_rx_port #(
        .CLKS_PER_BIT (CPB),
        .CNT_W        (16)
    ) dut (
        .clk_core (clk_core),
        .reset    (reset),
        .rx       (rx),
        .bus      (bus)
    );

    always #5 clk_core = ~clk_core;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h", tag, got, exp);
        end
    endtask

    // Line level for cycle c of a frame: start bit, 8 data bits LSB first, then stop level.
    function automatic logic frame_bit(input logic [7:0] b, input int c, input logic stop_val);
        if (c < CPB) return 1'b0;
        else if (c < 9 * CPB) return b[(c - CPB) / CPB];
        else return stop_val;
    endfunction

    // Drives one frame; rx is left at stop_val afterwards. Optional read pulse in stop-sample cycle.
    task automatic send_frame(input logic [7:0] b, input logic stop_val, input int stop_cycles,
                              input bit read_at_stop);
        for (int c = 0; c < 9 * CPB + stop_cycles; c++) begin
            @(negedge clk_core);
            rx          = frame_bit(b, c, stop_val);
            bus.rx_read = read_at_stop && (c == 9 * CPB + 6);
        end
        @(negedge clk_core);
        bus.rx_read = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_core);
            rx = 1'b1;
        end
    endtask

    task automatic pulse_read();
        @(negedge clk_core);
        bus.rx_read = 1'b1;
        @(negedge clk_core);
        bus.rx_read = 1'b0;
    endtask

    task automatic pulse_clr();
        @(negedge clk_core);
        bus.err_clr = 1'b1;
        @(negedge clk_core);
        bus.err_clr = 1'b0;
    endtask

    initial begin
        bus.rx_read = 1'b0;
        bus.err_clr = 1'b0;
        repeat (4) @(negedge clk_core);
        check_eq("rst_valid", 8'(bus.rx_valid), 8'd0);
        check_eq("rst_data", bus.rx_data, 8'h00);
        check_eq("rst_ferr", 8'(bus.frame_err), 8'd0);
        check_eq("rst_ovr", 8'(bus.overrun), 8'd0);
        check_eq("rst_busy", 8'(bus.busy), 8'd0);
        reset = 1'b0;
        idle(4);

        // 1: basic byte and pop
        send_frame(8'hA5, 1'b1, CPB, 1'b0);
        check_eq("t1_valid", 8'(bus.rx_valid), 8'd1);
        check_eq("t1_data", bus.rx_data, 8'hA5);
        check_eq("t1_ferr", 8'(bus.frame_err), 8'd0);
        check_eq("t1_ovr", 8'(bus.overrun), 8'd0);
        check_eq("t1_busy", 8'(bus.busy), 8'd0);
        pulse_read();
        check_eq("t1_pop", 8'(bus.rx_valid), 8'd0);
        check_eq("t1_hold", bus.rx_data, 8'hA5);
        idle(4);

        // 2: start-bit glitch
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_core);
            rx = 1'b0;
        end
        idle(2);
        check_eq("t2_busy_mid", 8'(bus.busy), 8'd1);
        idle(12);
        check_eq("t2_busy", 8'(bus.busy), 8'd0);
        check_eq("t2_valid", 8'(bus.rx_valid), 8'd0);
        check_eq("t2_ferr", 8'(bus.frame_err), 8'd0);
        check_eq("t2_ovr", 8'(bus.overrun), 8'd0);

        // 3: framing error with long break, then recovery
        send_frame(8'h3C, 1'b0, 20 * CPB, 1'b0);
        check_eq("t3_ferr", 8'(bus.frame_err), 8'd1);
        check_eq("t3_valid", 8'(bus.rx_valid), 8'd0);
        check_eq("t3_busy_brk", 8'(bus.busy), 8'd1);
        idle(6);
        check_eq("t3_busy_end", 8'(bus.busy), 8'd0);
        send_frame(8'h11, 1'b1, CPB, 1'b0);
        check_eq("t3_data", bus.rx_data, 8'h11);
        check_eq("t3_valid2", 8'(bus.rx_valid), 8'd1);
        check_eq("t3_ferr_sticky", 8'(bus.frame_err), 8'd1);
        pulse_clr();
        check_eq("t3_ferr_clr", 8'(bus.frame_err), 8'd0);
        pulse_read();
        idle(4);

        // 4: overrun
        send_frame(8'h01, 1'b1, CPB, 1'b0);
        idle(4);
        send_frame(8'h02, 1'b1, CPB, 1'b0);
        check_eq("t4_data", bus.rx_data, 8'h01);
        check_eq("t4_valid", 8'(bus.rx_valid), 8'd1);
        check_eq("t4_ovr", 8'(bus.overrun), 8'd1);
        check_eq("t4_ferr", 8'(bus.frame_err), 8'd0);
        pulse_clr();
        check_eq("t4_ovr_clr", 8'(bus.overrun), 8'd0);
        pulse_read();
        check_eq("t4_pop", 8'(bus.rx_valid), 8'd0);
        idle(4);

        // 5: read coinciding with commit replaces the byte without overrun
        send_frame(8'h55, 1'b1, CPB, 1'b0);
        idle(4);
        send_frame(8'h66, 1'b1, CPB, 1'b1);
        check_eq("t5_data", bus.rx_data, 8'h66);
        check_eq("t5_valid", 8'(bus.rx_valid), 8'd1);
        check_eq("t5_ovr", 8'(bus.overrun), 8'd0);
        pulse_read();
        check_eq("t5_pop", 8'(bus.rx_valid), 8'd0);
        idle(4);

        // 6: reset in the middle of DATA
        for (int c = 0; c < 5 * CPB; c++) begin
            @(negedge clk_core);
            rx = frame_bit(8'h7E, c, 1'b1);
        end
        check_eq("t6_busy_mid", 8'(bus.busy), 8'd1);
        @(negedge clk_core);
        reset = 1'b1;
        rx    = 1'b1;
        repeat (3) @(negedge clk_core);
        reset = 1'b0;
        idle(4);
        check_eq("t6_valid", 8'(bus.rx_valid), 8'd0);
        check_eq("t6_busy", 8'(bus.busy), 8'd0);
        check_eq("t6_ferr", 8'(bus.frame_err), 8'd0);
        send_frame(8'h7E, 1'b1, CPB, 1'b0);
        check_eq("t6_data", bus.rx_data, 8'h7E);
        check_eq("t6_valid2", 8'(bus.rx_valid), 8'd1);
        check_eq("t6_flags", {6'd0, bus.frame_err, bus.overrun}, 8'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
